// File: rtl/fp_mul_pkg.sv
// Shared types and widths for the FP mantissa multiplier datapath.
package fp_mul_pkg;

  // Hidden bit plus 26 fraction bits.
  localparam int unsigned MANT_W = 27;
  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned CNT_W  = $clog2(MANT_W);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mul_state_e;

endpackage : fp_mul_pkg

// File: rtl/mul_shift_add_step.sv
// One combinational shift-add iteration: conditionally accumulate, then shift both operands.
module mul_shift_add_step #(
  parameter int unsigned N = 27
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand_sh,
  input  logic [N-1:0]   mplr_sh,
  output logic [2*N-1:0] acc_next,
  output logic [2*N-1:0] mcand_next,
  output logic [N-1:0]   mplr_next
);

  // The partial sum never exceeds A*B, so the 2N-bit add cannot overflow.
  always_comb begin
    acc_next   = mplr_sh[0] ? (acc + mcand_sh) : acc;
    mcand_next = {mcand_sh[2*N-2:0], 1'b0};
    mplr_next  = {1'b0, mplr_sh[N-1:1]};
  end

endmodule : mul_shift_add_step

// File: rtl/mantissa_seq_multiplier.sv
// Iterative shift-add mantissa multiplier, one multiplier bit per clock.
// Optional build macro: MANT_MUL_EARLY_TERM_EN ends RUN once the remaining multiplier bits are zero.
module mantissa_seq_multiplier
  import fp_mul_pkg::*;
#(
  parameter int unsigned N = MANT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  mul_state_e     state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplr_q, mplr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;

  logic [2*N-1:0] acc_step;
  logic [2*N-1:0] mcand_step;
  logic [N-1:0]   mplr_step;
  logic           last_step;

  mul_shift_add_step #(
    .N (N)
  ) u_step (
    .acc        (acc_q),
    .mcand_sh   (mcand_q),
    .mplr_sh    (mplr_q),
    .acc_next   (acc_step),
    .mcand_next (mcand_step),
    .mplr_next  (mplr_step)
  );

  // Decide whether the current RUN cycle retires the final step.
  always_comb begin
`ifdef MANT_MUL_EARLY_TERM_EN
    last_step = (cnt_q == LastCnt) || (mplr_step == '0);
`else
    last_step = (cnt_q == LastCnt);
`endif
  end

  // Next-state logic: operand capture, RUN iteration and result load.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d   = '0;
          mcand_d = {{N{1'b0}}, multiplicand};
          mplr_d  = multiplier;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // start is ignored here; the in-flight operands are not re-sampled.
        acc_d   = acc_step;
        mcand_d = mcand_step;
        mplr_d  = mplr_step;
        cnt_d   = cnt_q + CntW'(1);
        if (last_step) begin
          product_d = acc_step;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; async reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy    = (state_q == StRun);
    done    = (state_q == StDone);
    product = product_q;
  end

endmodule : mantissa_seq_multiplier

// File: tb/tb_mantissa_seq_multiplier.sv
// Directed and random self-checking bench for mantissa_seq_multiplier.
module tb_mantissa_seq_multiplier;

  localparam int unsigned N = 27;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  mantissa_seq_multiplier #(
    .N (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Cycles from the start-driving cycle to the done cycle (RUN cycles + 1).
  function automatic int exp_cycles(input logic [N-1:0] b);
`ifdef MANT_MUL_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < int'(N); i++) if (b[i]) msb = i;
    return msb + 2;
`else
    return int'(N) + 1;
`endif
  endfunction

  // Issue one operation and wait (bounded) for done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [2*N-1:0] p, output int cyc);
    @(posedge clk); #1;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    cyc          = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (i == 0) check("busy_after_start", 64'(busy), 64'd1);
      if (done) break;
    end
    check("done_within_bound", 64'(done), 64'd1);
    p = product;
  endtask

  logic [2*N-1:0] p;
  logic [2*N-1:0] prev_p;
  logic [N-1:0]   ra, rb;
  int             cyc;
  int             cyc2;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: small product and fixed latency; done is a single-cycle pulse.
    run_op(27'd5, 27'd3, p, cyc);
    check("t1_product", 64'(p), 64'd15);
    check("t1_latency", 64'(cyc), 64'(exp_cycles(27'd3)));
    @(posedge clk); #1;
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_product_held", 64'(product), 64'd15);

    // 2: largest operands fill 2N bits exactly.
    run_op(27'h7FFFFFF, 27'h7FFFFFF, p, cyc);
    check("t2_product", 64'(p), 64'h3FFFFFF0000001);
    check("t2_latency", 64'(cyc), 64'd28);

    // 3: 1.0 * 1.0; the multiplier msb forces all 27 steps in either build.
    run_op(27'h4000000, 27'h4000000, p, cyc);
    check("t3_product", 64'(p), 64'h10000000000000);
    check("t3_latency", 64'(cyc), 64'd28);

    // 4: zero and unit multipliers.
    run_op(27'h5A5A5A5, 27'd0, p, cyc);
    check("t4_zero_product", 64'(p), 64'd0);
    check("t4_zero_latency", 64'(cyc), 64'(exp_cycles(27'd0)));
    run_op(27'h5A5A5A5, 27'd1, p, cyc);
    check("t4_one_product", 64'(p), 64'h5A5A5A5);
    check("t4_one_latency", 64'(cyc), 64'(exp_cycles(27'd1)));
    run_op(27'd0, 27'h1234567, p, cyc);
    check("t4_zero_a_product", 64'(p), 64'd0);

    // 5: start held through RUN and DONE; operands changed mid-RUN are ignored,
    // then accepted as the next operation in the DONE cycle.
    prev_p = product;
    @(posedge clk); #1;
    multiplicand = 27'h123;
    multiplier   = 27'h456;
    start        = 1'b1;
    cyc          = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        multiplicand = 27'd3;
        multiplier   = 27'd7;
      end
      if (cyc == 2) check("t5_product_stable_run", 64'(product), 64'(prev_p));
      if (done) break;
    end
    check("t5_first_done", 64'(done), 64'd1);
    check("t5_first_product", 64'(product), 64'h4EDC2);
    check("t5_first_latency", 64'(cyc), 64'(exp_cycles(27'h456)));
    cyc2 = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc2++;
      start = 1'b0;
      if (cyc2 == 1) check("t5_back_to_back_busy", 64'(busy), 64'd1);
      if (cyc2 == 2) check("t5_product_held_run", 64'(product), 64'h4EDC2);
      if (done) break;
    end
    check("t5_second_done", 64'(done), 64'd1);
    check("t5_second_product", 64'(product), 64'd21);
    check("t5_second_latency", 64'(cyc2), 64'(exp_cycles(27'd7)));

    // 6: asynchronous reset mid-RUN aborts, then the block recovers.
    @(posedge clk); #1;
    multiplicand = 27'h7FFFFFF;
    multiplier   = 27'h7FFFFFF;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    check("t6_busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_busy", 64'(busy), 64'd0);
    check("t6_reset_done", 64'(done), 64'd0);
    check("t6_reset_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 27) check("t6_no_done_after_abort", 64'(done), 64'd0);
    end
    run_op(27'd6, 27'd7, p, cyc);
    check("t6_recover_product", 64'(p), 64'd42);
    check("t6_recover_latency", 64'(cyc), 64'(exp_cycles(27'd7)));

    // Random operand pairs against a 64-bit reference multiply.
    for (int k = 0; k < 200; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (k % 8 == 1) rb = rb >> $urandom_range(26, 1);
      run_op(ra, rb, p, cyc);
      check("rand_product", 64'(p), 64'(ra) * 64'(rb));
      check("rand_latency", 64'(cyc), 64'(exp_cycles(rb)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mantissa_seq_multiplier
